// File: rtl/state_trace_monitor_if.sv
// Bundles the monitored state word, its sample enable and the trace results.
// Latency: wiring only; none.
// Backpressure: none; the monitor samples whenever en is high and never stalls its source.
interface state_trace_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       state;
    logic [CNT_W-1:0] trans_cnt;
    logic [CNT_W-1:0] dwell;
    logic             stall;
    logic             seq_hit;
    logic [CNT_W-1:0] hit_cnt;

    // Source side: drives the enable and the state it wants watched.
    modport master (
        output en,
        output state,
        input  trans_cnt,
        input  dwell,
        input  stall,
        input  seq_hit,
        input  hit_cnt
    );

    // Monitor side: consumes the state and reports the trace results.
    modport slave (
        input  en,
        input  state,
        output trans_cnt,
        output dwell,
        output stall,
        output seq_hit,
        output hit_cnt
    );
endinterface

// File: rtl/state_trace_monitor.sv
// Traces a 2-bit FSM state: counts changes, measures dwell/stall, detects a 3-state visit sequence.
// Latency: 1 cycle from a sampling edge to every output; stall is combinational off the registered dwell.
// Backpressure: none; en=0 freezes all state and forces seq_hit low.
module state_trace_monitor #(
    parameter int         CNT_W     = 8,
    parameter int         DWELL_MAX = 4,
    parameter logic [5:0] SEQ       = 6'b00_11_01
) (
    input  logic                 clk,
    input  logic                 res,
    state_trace_monitor_if.slave mon
);
    localparam logic [1:0]       SEQ_A     = SEQ[5:4];
    localparam logic [1:0]       SEQ_B     = SEQ[3:2];
    localparam logic [1:0]       SEQ_C     = SEQ[1:0];
    // A sequence with a repeated adjacent state can never be seen, since
    // only changes of state are presented to the detector.
    localparam bit               SEQ_OK    = (SEQ_A != SEQ_B) && (SEQ_B != SEQ_C);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_MAX);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // no progress
        S1 = 2'd1,  // last distinct value was a
        S2 = 2'd2   // last two distinct values were a, b
    } det_t;

    det_t             det_q;
    det_t             det_d;
    logic             hit_d;
    logic [1:0]       prev_q;
    logic             has_prev_q;
    logic [CNT_W-1:0] trans_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic             seq_hit_q;
    logic             evt;

    // A detector event is any sample that presents a new distinct value;
    // the first sample after reset always counts as new.
    assign evt = mon.en && (!has_prev_q || (mon.state != prev_q));

    // Detector state register.
    always_ff @(posedge clk) begin
        if (!res) begin
            det_q <= S0;
        end else begin
            det_q <= det_d;
        end
    end

    // Detector next state and hit decision; only moves on detector events.
    always_comb begin
        det_d = det_q;
        hit_d = 1'b0;
        if (evt) begin
            case (det_q)
                S0: det_d = (mon.state == SEQ_A) ? S1 : S0;
                S1: det_d = (mon.state == SEQ_B) ? S2 : S0;
                S2: begin
                    hit_d = SEQ_OK && (mon.state == SEQ_C);
                    // Completing value may itself start the next match.
                    det_d = (mon.state == SEQ_A) ? S1 : S0;
                end
                default: det_d = S0;
            endcase
        end
    end

    // Sample history, saturating transition/dwell/hit counters and the hit pulse.
    always_ff @(posedge clk) begin
        if (!res) begin
            prev_q     <= 2'b00;
            has_prev_q <= 1'b0;
            trans_q    <= '0;
            dwell_q    <= '0;
            hit_cnt_q  <= '0;
            seq_hit_q  <= 1'b0;
        end else begin
            seq_hit_q <= hit_d;
            if (mon.en) begin
                if (!has_prev_q) begin
                    prev_q     <= mon.state;
                    has_prev_q <= 1'b1;
                    dwell_q    <= '0;
                end else if (mon.state == prev_q) begin
                    if (dwell_q != CNT_MAX) begin
                        dwell_q <= dwell_q + CNT_ONE;
                    end
                end else begin
                    if (trans_q != CNT_MAX) begin
                        trans_q <= trans_q + CNT_ONE;
                    end
                    dwell_q <= '0;
                    prev_q  <= mon.state;
                end
                if (hit_d && (hit_cnt_q != CNT_MAX)) begin
                    hit_cnt_q <= hit_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign mon.trans_cnt = trans_q;
    assign mon.dwell     = dwell_q;
    assign mon.stall     = (dwell_q >= DWELL_LIM);
    assign mon.seq_hit   = seq_hit_q;
    assign mon.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_state_trace_monitor.sv
// Directed bench for state_trace_monitor: default-SEQ instance plus an overlapping-SEQ instance.
// Latency: outputs checked 1 ns after each sampling edge.
// Backpressure: none; stimulus is purely cycle-driven.
module tb_state_trace_monitor;
    logic clk;
    logic res;
    int   checks;
    int   failures;

    state_trace_monitor_if #(.CNT_W(8)) ifa ();
    state_trace_monitor_if #(.CNT_W(8)) ifb ();

    state_trace_monitor #(.CNT_W(8), .DWELL_MAX(4), .SEQ(6'b00_11_01)) dut_a (
        .clk (clk),
        .res (res),
        .mon (ifa)
    );

    state_trace_monitor #(.CNT_W(8), .DWELL_MAX(4), .SEQ(6'b00_01_00)) dut_b (
        .clk (clk),
        .res (res),
        .mon (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock on instance A with res released.
    task automatic step_a(input logic [1:0] st, input logic e);
        @(negedge clk);
        res       = 1'b1;
        ifa.en    = e;
        ifa.state = st;
        ifb.en    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock on instance B with res released.
    task automatic step_b(input logic [1:0] st);
        @(negedge clk);
        res       = 1'b1;
        ifb.en    = 1'b1;
        ifb.state = st;
        ifa.en    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One reset edge with both instances enabled and their state moving.
    task automatic pulse_reset();
        @(negedge clk);
        res       = 1'b0;
        ifa.en    = 1'b1;
        ifb.en    = 1'b1;
        ifa.state = ~ifa.state;
        ifb.state = ~ifb.state;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_a(2'b00, 1'b1);
        step_a(2'b11, 1'b1);
        step_a(2'b11, 1'b1);
        pulse_reset();
        checks++;
        if ({ifa.trans_cnt, ifa.dwell, ifa.stall, ifa.seq_hit, ifa.hit_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL reset_a got trans=%0d dwell=%0d stall=%0b hit=%0b hits=%0d want all 0",
                     ifa.trans_cnt, ifa.dwell, ifa.stall, ifa.seq_hit, ifa.hit_cnt);
        end
        checks++;
        if ({ifb.trans_cnt, ifb.dwell, ifb.stall, ifb.seq_hit, ifb.hit_cnt} !== 26'd0) begin
            failures++;
            $display("FAIL reset_b got trans=%0d dwell=%0d stall=%0b hit=%0b hits=%0d want all 0",
                     ifb.trans_cnt, ifb.dwell, ifb.stall, ifb.seq_hit, ifb.hit_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] seq_in [7] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
        logic       hit_exp[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            step_a(seq_in[i], 1'b1);
            checks++;
            if (ifa.seq_hit !== hit_exp[i]) begin
                failures++;
                $display("FAIL seq_hit[%0d] got=%b want=%b", i, ifa.seq_hit, hit_exp[i]);
            end
        end
        checks++;
        if (ifa.trans_cnt !== 8'd6) begin
            failures++;
            $display("FAIL seq_trans got=%0d want=6", ifa.trans_cnt);
        end
        checks++;
        if (ifa.hit_cnt !== 8'd2) begin
            failures++;
            $display("FAIL seq_hit_cnt got=%0d want=2", ifa.hit_cnt);
        end
        step_a(2'b01, 1'b0);
        checks++;
        if (ifa.seq_hit !== 1'b0) begin
            failures++;
            $display("FAIL seq_hit_drop got=%b want=0", ifa.seq_hit);
        end
    endtask

    task automatic test_dwell();
        pulse_reset();
        step_a(2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step_a(2'b11, 1'b1);
        checks++;
        if (ifa.dwell !== 8'd3 || ifa.stall !== 1'b0) begin
            failures++;
            $display("FAIL dwell_below got dwell=%0d stall=%b want 3/0", ifa.dwell, ifa.stall);
        end
        step_a(2'b11, 1'b1);
        checks++;
        if (ifa.dwell !== 8'd4 || ifa.stall !== 1'b1) begin
            failures++;
            $display("FAIL dwell_at_max got dwell=%0d stall=%b want 4/1", ifa.dwell, ifa.stall);
        end
        step_a(2'b01, 1'b1);
        checks++;
        if (ifa.dwell !== 8'd0 || ifa.stall !== 1'b0 || ifa.trans_cnt !== 8'd2) begin
            failures++;
            $display("FAIL dwell_clear got dwell=%0d stall=%b trans=%0d want 0/0/2",
                     ifa.dwell, ifa.stall, ifa.trans_cnt);
        end
        // 00 -> 11 -> 01 is also a complete default sequence
        checks++;
        if (ifa.seq_hit !== 1'b1 || ifa.hit_cnt !== 8'd1) begin
            failures++;
            $display("FAIL dwell_seq got hit=%b hits=%0d want 1/1", ifa.seq_hit, ifa.hit_cnt);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 10; i++) step_a((i % 2 == 0) ? 2'b00 : ((i == 5) ? 2'bxx : 2'b11), 1'b0);
        checks++;
        if ({ifa.trans_cnt, ifa.dwell, ifa.stall, ifa.seq_hit, ifa.hit_cnt}
            !== {8'd2, 8'd0, 1'b0, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL en_hold got trans=%0d dwell=%0d stall=%b hit=%b hits=%0d want 2/0/0/0/1",
                     ifa.trans_cnt, ifa.dwell, ifa.stall, ifa.seq_hit, ifa.hit_cnt);
        end
        step_a(2'b00, 1'b1);
        step_a(2'b11, 1'b1);
        checks++;
        if (ifa.seq_hit !== 1'b0) begin
            failures++;
            $display("FAIL en_early_hit got=%b want=0", ifa.seq_hit);
        end
        step_a(2'b01, 1'b1);
        checks++;
        if (ifa.seq_hit !== 1'b1 || ifa.hit_cnt !== 8'd2 || ifa.trans_cnt !== 8'd5) begin
            failures++;
            $display("FAIL en_resume got hit=%b hits=%0d trans=%0d want 1/2/5",
                     ifa.seq_hit, ifa.hit_cnt, ifa.trans_cnt);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 255; i++) step_a((i % 2 == 0) ? 2'b00 : 2'b11, 1'b1);
        checks++;
        if (ifa.trans_cnt !== 8'd254) begin
            failures++;
            $display("FAIL sat_trans_below got=%0d want=254", ifa.trans_cnt);
        end
        for (int i = 255; i < 300; i++) step_a((i % 2 == 0) ? 2'b00 : 2'b11, 1'b1);
        checks++;
        if (ifa.trans_cnt !== 8'd255 || ifa.hit_cnt !== 8'd0) begin
            failures++;
            $display("FAIL sat_trans got trans=%0d hits=%0d want 255/0", ifa.trans_cnt, ifa.hit_cnt);
        end
        // last sample (i=299) was 11; hold it long enough to pin dwell
        for (int i = 0; i < 260; i++) step_a(2'b11, 1'b1);
        checks++;
        if (ifa.dwell !== 8'd255 || ifa.stall !== 1'b1 || ifa.trans_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_dwell got dwell=%0d stall=%b trans=%0d want 255/1/255",
                     ifa.dwell, ifa.stall, ifa.trans_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [1:0] seq_in [5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        logic       hit_exp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step_b(seq_in[i]);
            checks++;
            if (ifb.seq_hit !== hit_exp[i]) begin
                failures++;
                $display("FAIL overlap_hit[%0d] got=%b want=%b", i, ifb.seq_hit, hit_exp[i]);
            end
        end
        checks++;
        if (ifb.hit_cnt !== 8'd2 || ifb.trans_cnt !== 8'd4) begin
            failures++;
            $display("FAIL overlap_cnt got hits=%0d trans=%0d want 2/4", ifb.hit_cnt, ifb.trans_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        step_a(2'b00, 1'b1);
        step_a(2'b11, 1'b1);
        pulse_reset();
        step_a(2'b01, 1'b1);
        checks++;
        if (ifa.seq_hit !== 1'b0 || ifa.trans_cnt !== 8'd0 || ifa.hit_cnt !== 8'd0 || ifa.dwell !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid got hit=%b trans=%0d hits=%0d dwell=%0d want 0/0/0/0",
                     ifa.seq_hit, ifa.trans_cnt, ifa.hit_cnt, ifa.dwell);
        end
        // 01 after reset is a first sample; a following 01 must only grow dwell
        step_a(2'b01, 1'b1);
        checks++;
        if (ifa.dwell !== 8'd1 || ifa.trans_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_first got dwell=%0d trans=%0d want 1/0", ifa.dwell, ifa.trans_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        res       = 1'b0;
        ifa.en    = 1'b0;
        ifa.state = 2'b00;
        ifb.en    = 1'b0;
        ifb.state = 2'b00;
        repeat (2) @(posedge clk);
        test_reset();
        test_sequence();
        test_dwell();
        test_enable();
        test_saturation();
        test_overlap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
